// File: rtl/noc_link_tx.sv
// Chip-edge link transmitter: per-channel flit FIFOs, round-robin frame
// arbitration and serialisation onto a narrow credit-controlled link.
module noc_link_tx #(
  parameter int FW        = 36,
  parameter int NCH       = 2,
  parameter int B         = 4,
  parameter int LW        = 12,
  parameter int LINK_CRED = 8,
  parameter int CHW       = (NCH > 1) ? $clog2(NCH) : 1,
  parameter int FRW       = CHW + FW,
  parameter int SER       = (FRW + LW - 1) / LW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH*FW-1:0] flit_in,
  input  logic [NCH-1:0]    flit_in_wr,
  output logic [NCH-1:0]    credit_out,
  output logic [LW-1:0]     link_data,
  output logic              link_valid,
  output logic              link_sof,
  input  logic              link_credit_in,
  output logic [NCH-1:0]    ovf_err,
  output logic              cred_err,
  output logic              busy
);
  localparam int CW   = $clog2(B + 1);
  localparam int PW   = (B > 1) ? $clog2(B) : 1;
  localparam int BW   = (SER > 1) ? $clog2(SER) : 1;
  localparam int CRW  = $clog2(LINK_CRED + 1);
  localparam int PADW = SER * LW;

  typedef enum logic {IDLE, SEND} state_t;

  logic [FW-1:0]   mem_q   [NCH][B];
  logic [PW-1:0]   rdPtr_q [NCH];
  logic [PW-1:0]   wrPtr_q [NCH];
  logic [CW-1:0]   cnt_q   [NCH];
  logic [NCH-1:0]  ovf_q;

  state_t          state_q;
  logic [BW-1:0]   beat_q;
  logic [PADW-1:0] frame_q;
  logic [LW-1:0]   linkData_q;
  logic            linkValid_q;
  logic            linkSof_q;
  logic [CHW-1:0]  last_q;
  logic [CRW-1:0]  credCnt_q, credCnt_d;
  logic            credErr_q, credErr_d;

  logic            grant;
  logic [CHW-1:0]  winner;
  logic [CHW-1:0]  cand;
  logic [NCH-1:0]  pop;
  logic [NCH-1:0]  wrOk;
  logic [PADW-1:0] frameNext;
  logic            anyPending;

  function automatic logic [PW-1:0] incPtr(input logic [PW-1:0] p);
    return (p == PW'(B - 1)) ? '0 : p + 1'b1;
  endfunction

  // Grant only from registered state, so a credit arriving at zero takes effect next cycle
  always_comb begin
    grant  = 1'b0;
    winner = '0;
    cand   = '0;
    pop    = '0;
    if ((state_q == IDLE || beat_q == BW'(SER - 1)) && credCnt_q != '0) begin
      for (int i = 1; i <= NCH; i++) begin
        cand = CHW'((int'(last_q) + i) % NCH);
        if (!grant && cnt_q[cand] != '0) begin
          grant  = 1'b1;
          winner = cand;
        end
      end
    end
    pop[winner] = grant;
    frameNext = '0;
    frameNext[FRW-1:0] = {winner, mem_q[winner][rdPtr_q[winner]]};
  end

  always_comb begin
    wrOk       = '0;
    anyPending = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      wrOk[c] = flit_in_wr[c] && (cnt_q[c] != CW'(B) || pop[c]);
      if (cnt_q[c] != '0) anyPending = 1'b1;
    end
  end

  always_comb begin
    credCnt_d = credCnt_q;
    credErr_d = credErr_q;
    if (link_credit_in && !grant) begin
      if (credCnt_q == CRW'(LINK_CRED)) credErr_d = 1'b1;
      else                              credCnt_d = credCnt_q + 1'b1;
    end else if (grant && !link_credit_in) begin
      credCnt_d = credCnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (wrOk[c]) mem_q[c][wrPtr_q[c]] <= flit_in[FW*c +: FW];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        rdPtr_q[c] <= '0;
        wrPtr_q[c] <= '0;
        cnt_q[c]   <= '0;
      end
      ovf_q <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (wrOk[c]) wrPtr_q[c] <= incPtr(wrPtr_q[c]);
        if (pop[c])  rdPtr_q[c] <= incPtr(rdPtr_q[c]);
        if (wrOk[c] && !pop[c])      cnt_q[c] <= cnt_q[c] + 1'b1;
        else if (!wrOk[c] && pop[c]) cnt_q[c] <= cnt_q[c] - 1'b1;
        if (flit_in_wr[c] && !wrOk[c]) ovf_q[c] <= 1'b1;
      end
    end
  end

  // beat_q indexes the beat currently on the link; a grant on the last beat chains frames
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      frame_q     <= '0;
      linkData_q  <= '0;
      linkValid_q <= 1'b0;
      linkSof_q   <= 1'b0;
      last_q      <= CHW'(NCH - 1);
      credCnt_q   <= CRW'(LINK_CRED);
      credErr_q   <= 1'b0;
    end else begin
      credCnt_q <= credCnt_d;
      credErr_q <= credErr_d;
      if (grant) begin
        state_q     <= SEND;
        beat_q      <= '0;
        frame_q     <= frameNext;
        linkData_q  <= frameNext[LW-1:0];
        linkValid_q <= 1'b1;
        linkSof_q   <= 1'b1;
        last_q      <= winner;
      end else if (state_q == SEND && beat_q != BW'(SER - 1)) begin
        beat_q      <= beat_q + 1'b1;
        linkData_q  <= frame_q[LW*(int'(beat_q) + 1) +: LW];
        linkValid_q <= 1'b1;
        linkSof_q   <= 1'b0;
      end else begin
        state_q     <= IDLE;
        linkValid_q <= 1'b0;
        linkSof_q   <= 1'b0;
      end
    end
  end

  assign credit_out = pop;
  assign link_data  = linkData_q;
  assign link_valid = linkValid_q;
  assign link_sof   = linkSof_q;
  assign ovf_err    = ovf_q;
  assign cred_err   = credErr_q;
  assign busy       = anyPending || (state_q == SEND);

endmodule

// File: tb/tb_noc_link_tx.sv
// Scoreboard bench for noc_link_tx: a frame-level reference model predicts every
// link beat and per-cycle status; a separate monitor checks the link.
module tb_noc_link_tx;
  localparam int FW        = 36;
  localparam int NCH       = 2;
  localparam int B         = 4;
  localparam int LW        = 12;
  localparam int LINK_CRED = 8;
  localparam int CHW       = 1;
  localparam int FRW       = CHW + FW;
  localparam int SER       = (FRW + LW - 1) / LW;

  logic              clk;
  logic              rst_n;
  logic [NCH*FW-1:0] flit_in;
  logic [NCH-1:0]    flit_in_wr;
  logic [NCH-1:0]    credit_out;
  logic [LW-1:0]     link_data;
  logic              link_valid;
  logic              link_sof;
  logic              link_credit_in;
  logic [NCH-1:0]    ovf_err;
  logic              cred_err;
  logic              busy;

  noc_link_tx #(
    .FW(FW), .NCH(NCH), .B(B), .LW(LW), .LINK_CRED(LINK_CRED)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flit_in(flit_in), .flit_in_wr(flit_in_wr),
    .credit_out(credit_out), .link_data(link_data), .link_valid(link_valid),
    .link_sof(link_sof), .link_credit_in(link_credit_in), .ovf_err(ovf_err),
    .cred_err(cred_err), .busy(busy)
  );

  typedef struct {
    logic [LW-1:0] data;
    logic          sof;
    int            cyc;
  } beat_t;

  beat_t          expQ [$];
  logic [FW-1:0]  fifoM [NCH][B];
  int             fifoN [NCH];
  int             credits;
  int             lastG;
  int             linkEnd;
  logic [NCH-1:0] ovfM;
  logic           credErrM;
  int             cycle;
  int             total;
  int             bad;
  logic [LW-1:0]  lastData;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic resetModel();
    for (int c = 0; c < NCH; c++) fifoN[c] = 0;
    credits  = LINK_CRED;
    lastG    = NCH - 1;
    linkEnd  = -1;
    ovfM     = '0;
    credErrM = 1'b0;
    expQ.delete();
  endtask

  // One cycle of the reference behaviour, using the inputs presented this cycle
  task automatic modelStep();
    int win;
    logic [NCH-1:0] expPop;
    logic [63:0] fv;
    bit anyQ;
    win    = -1;
    expPop = '0;
    anyQ   = 0;
    if (cycle >= linkEnd && credits > 0) begin
      for (int i = 1; i <= NCH; i++) begin
        int c;
        c = (lastG + i) % NCH;
        if (win < 0 && fifoN[c] > 0) win = c;
      end
    end
    if (win >= 0) expPop[win] = 1'b1;
    for (int c = 0; c < NCH; c++) if (fifoN[c] > 0) anyQ = 1;
    checkOutput("credit_out", credit_out, expPop);
    checkOutput("busy", busy, anyQ || (cycle <= linkEnd));
    checkOutput("ovf_err", ovf_err, ovfM);
    checkOutput("cred_err", cred_err, credErrM);
    if (win >= 0) begin
      fv = (64'(win) << FW) | 64'(fifoM[win][0]);
      for (int k = 1; k < B; k++) fifoM[win][k-1] = fifoM[win][k];
      fifoN[win]--;
      for (int b = 0; b < SER; b++)
        expQ.push_back('{data: LW'(fv >> (LW * b)), sof: (b == 0), cyc: cycle + 1 + b});
      linkEnd = cycle + SER;
      lastG   = win;
    end
    if (win >= 0 && !link_credit_in) credits--;
    else if (link_credit_in && win < 0) begin
      if (credits == LINK_CRED) credErrM = 1'b1;
      else credits++;
    end
    for (int c = 0; c < NCH; c++) begin
      if (flit_in_wr[c]) begin
        if (fifoN[c] < B) begin
          fifoM[c][fifoN[c]] = flit_in[FW*c +: FW];
          fifoN[c]++;
        end else begin
          ovfM[c] = 1'b1;
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic [NCH-1:0] wr, input logic [FW-1:0] f0,
                               input logic [FW-1:0] f1, input logic cin);
    @(negedge clk);
    flit_in_wr     = wr;
    flit_in        = {f1, f0};
    link_credit_in = cin;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus('0, '0, '0, 1'b0);
  endtask

  function automatic logic [FW-1:0] rndFlit();
    return {$urandom, $urandom};
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle index: cycle k is the interval following the k-th rising edge
  initial begin
    cycle = 0;
    forever begin
      @(posedge clk);
      cycle++;
    end
  end

  // Reference model runs just after the stimulus settles on each falling edge
  initial begin
    resetModel();
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) resetModel();
      else modelStep();
    end
  end

  // Link monitor: pops expected beats and checks data, sof, timing and hold
  initial begin
    beat_t e;
    lastData = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        lastData = '0;
      end else if (link_valid) begin
        total++;
        if (expQ.size() == 0) begin
          bad++;
          $display("[TB] FAIL extra_beat: got data %0h expected no beat (cycle %0d)", link_data, cycle);
        end else begin
          e = expQ.pop_front();
          checkOutput("link_data", link_data, e.data);
          checkOutput("link_sof", link_sof, e.sof);
          checkOutput("beat_cycle", cycle, e.cyc);
        end
        lastData = link_data;
      end else begin
        checkOutput("link_hold", link_data, lastData);
        checkOutput("idle_sof", link_sof, 1'b0);
        if (expQ.size() > 0 && expQ[0].cyc <= cycle) begin
          e = expQ.pop_front();
          total++;
          bad++;
          $display("[TB] FAIL missing_beat: got no beat expected data %0h (cycle %0d)", e.data, cycle);
        end
      end
    end
  end

  // Directed scenarios followed by a randomized phase and a bounded drain
  initial begin
    bit drained;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    flit_in_wr = '0;
    flit_in = '0;
    link_credit_in = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset link_valid", link_valid, 1'b0);
    checkOutput("reset link_sof", link_sof, 1'b0);
    checkOutput("reset link_data", link_data, '0);
    checkOutput("reset credit_out", credit_out, '0);
    checkOutput("reset ovf_err", ovf_err, '0);
    checkOutput("reset cred_err", cred_err, 1'b0);
    checkOutput("reset busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(2'b10, '0, 36'h9ABCD1234, 1'b0);
    idle(8);

    applyStimulus(2'b11, 36'h111111111, 36'h222222222, 1'b0);
    idle(12);
    applyStimulus(2'b11, 36'h333333333, 36'h444444444, 1'b0);
    idle(12);

    repeat (5) applyStimulus('0, '0, '0, 1'b1);
    repeat (4) applyStimulus(2'b01, rndFlit(), '0, 1'b0);
    idle(20);
    repeat (5) applyStimulus(2'b10, '0, rndFlit(), 1'b0);
    idle(40);
    applyStimulus('0, '0, '0, 1'b1);
    idle(10);

    repeat (5) applyStimulus(2'b01, rndFlit(), '0, 1'b0);
    idle(5);
    repeat (8) applyStimulus('0, '0, '0, 1'b1);
    idle(25);
    repeat (4) applyStimulus('0, '0, '0, 1'b1);
    idle(2);

    applyStimulus('0, '0, '0, 1'b1);
    idle(2);
    applyStimulus(2'b01, 36'hABCABCABC, '0, 1'b0);
    applyStimulus('0, '0, '0, 1'b1);
    idle(8);

    applyStimulus(2'b01, 36'h0F0F0F0F0, '0, 1'b0);
    idle(3);
    @(negedge clk);
    rst_n = 1'b0;
    flit_in_wr = '0;
    link_credit_in = 1'b0;
    #1;
    checkOutput("midreset link_valid", link_valid, 1'b0);
    checkOutput("midreset busy", busy, 1'b0);
    checkOutput("midreset cred_err", cred_err, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(2'b10, '0, 36'h5A5A5A5A5, 1'b0);
    idle(8);

    for (int i = 0; i < 600; i++) begin
      applyStimulus({($urandom_range(2) == 0), ($urandom_range(2) == 0)},
                    rndFlit(), rndFlit(), ($urandom_range(3) == 0));
    end

    drained = 0;
    for (int i = 0; i < 400 && !drained; i++) begin
      applyStimulus('0, '0, '0, (i % 3 == 0));
      drained = (expQ.size() == 0);
      for (int c = 0; c < NCH; c++) if (fifoN[c] != 0) drained = 0;
    end
    checkOutput("drain timeout", drained, 1'b1);
    idle(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/noc_link_tx.md
Name: noc_link_tx

Overview:
- Parametrised chip-boundary transmitter for the mesh edge.
- Collects NCH edge channels (flit + write strobe, credit-based towards the mesh routers) into per-channel FIFOs.
- Round-robin arbitrates among channels and serialises each {channel id, flit} frame onto a narrow LW-bit off-chip link.
- Link flow control is credit-based. Successor to the fixed-width, one-wire-per-port chip connection: adds width conversion, channel muxing and link credit tracking.

Parameters:
- FW, 36, flit width.
- NCH, 2, number of edge channels muxed onto one link.
- B, 4, per-channel FIFO depth; equals the credits held by the mesh router driving each channel.
- LW, 12, link data width per beat.
- LINK_CRED, 8, frame slots available in the remote receiver after reset.
- CHW, (NCH>1 ? $clog2(NCH) : 1), channel id width (derived).
- FRW, CHW+FW, frame width (derived).
- SER, (FRW+LW-1)/LW, beats per frame (derived; must be >=1).

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- flit_in  input  NCH*FW  channel c flit at [FW*(c+1)-1 : FW*c].
- flit_in_wr  input  NCH  per-channel write strobe, one cycle per flit.
- credit_out  output  NCH  per-channel one-cycle credit pulse to the mesh router.
- link_data  output  LW  serialised beat.
- link_valid  output  1  beat valid.
- link_sof  output  1  first beat of a frame.
- link_credit_in  input  1  one-cycle pulse: remote freed one frame slot.
- ovf_err  output  NCH  sticky: write to a full FIFO.
- cred_err  output  1  sticky: credit return beyond LINK_CRED.
- busy  output  1  any FIFO non-empty or frame in flight.

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous, active-low. All state clears on assertion, including mid-frame; a partial frame is abandoned, no further beats.
- Reset values: credit_out=0, link_data=0, link_valid=0, link_sof=0, ovf_err=0, cred_err=0, busy=0, FIFOs empty, link credit counter=LINK_CRED, RR pointer=channel 0 highest priority, FSM=IDLE.
- FIFO write: accepted if count<B, or if the same channel pops that cycle. Otherwise the flit is dropped and ovf_err[c] is set. Simultaneous write+pop leaves count unchanged.
- Eligibility: a channel is eligible when its FIFO is non-empty and the link credit counter is >0.
- Arbitration occurs in IDLE, or in SEND on the last beat (beat==SER-1).
- Round-robin grant: search from last_grant+1 upward with wrap. Winner is popped, and its credit_out[c] pulses in that same cycle. The frame register loads {c[CHW-1:0], flit}. The link credit counter decrements. FSM goes to/stays in SEND with beat=0.
- SEND: each cycle drives link_valid=1 with link_data = frame[LW*beat +: LW]; the last beat is zero-padded above FRW. link_sof=1 only on beat 0. beat increments.
- After beat SER-1: if a new grant happened that cycle, the next cycle starts beat 0 of the new frame with no bubble; else go to IDLE with link_valid=0.
- Outputs are registered; link_data holds its last value when link_valid=0.
- Latency: flit_in_wr at cycle t → FIFO non-empty at t+1 → grant/pop at t+1 → beat 0 on link at t+2 (empty FIFOs, IDLE, credit>0).
- Link credit counter range 0..LINK_CRED. Decrement on grant; increment on link_credit_in; both in the same cycle leave it unchanged.
- Increment at LINK_CRED with no grant is ignored and sets cred_err.
- At counter 0 no grant occurs. A credit arriving in the cycle the counter is 0 enables a grant the next cycle, not the same cycle.
- SER==1: every cycle may launch a frame; link_sof=1 on every valid beat.
- busy = any FIFO non-empty OR state==SEND.

Test Plan:
- Reset then ch1 writes 36'h9ABCD1234 (FW=36, NCH=2, LW=12, SER=4) → credit_out[1] pulses at t+1; beats at t+2..t+5 = 12'h234 (sof=1), 12'hCD1, 12'h9AB, 12'h001 (sof=0); link_valid low at t+6.
- Both channels write in the same cycle after reset → ch0 frame first (beats 0-3), ch1 frame immediately follows, sof on cycles t+2 and t+6, no gap; next contention grants ch0 again (pointer after ch1).
- LINK_CRED=8, ch0 sends 4 flits, then ch1 sends 5 flits with no link_credit_in → exactly 8 frames sent, 9th waits. Pulse link_credit_in once → 9th frame's sof appears 2 cycles later.
- Write ch0 five times back-to-back while credit counter is 0 → FIFO holds 4, ovf_err[0]=1 after 5th write, ch1 unaffected. Restore credit → exactly 4 frames sent.
- link_credit_in pulsed with counter already at LINK_CRED and no traffic → cred_err=1, counter stays 8; it simultaneously with a grant → counter unchanged, no error.
- Assert rst_n low during beat 2 of a frame → link_valid=0 immediately, FIFOs empty, counter=LINK_CRED; after release a new flit sends a full frame starting with sof.
